// File: rtl/imem_boot_arbiter.sv
// Single-port instruction memory arbiter: boot-load from a streaming loader,
// then serve core fetches with single-cycle debug read-back steals.
module imem_boot_arbiter #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_valid_i,
    input  logic [DATA_WIDTH-1:0] ld_data_i,
    input  logic                  ld_last_i,
    output logic                  ld_ready_o,
    input  logic                  reload_i,
    input  logic [ADDR_WIDTH-1:0] fetch_addr_i,
    output logic [DATA_WIDTH-1:0] fetch_instr_o,
    output logic                  core_stall_o,
    output logic                  fetch_fault_o,
    input  logic                  dbg_req_i,
    input  logic [ADDR_WIDTH-1:0] dbg_addr_i,
    output logic                  dbg_ack_o,
    output logic [DATA_WIDTH-1:0] dbg_rdata_o,
    output logic [ADDR_WIDTH-3:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  load_done_o,
    output logic                  load_err_o,
    output logic [ADDR_WIDTH-2:0] word_count_o
);

    localparam int unsigned WA    = ADDR_WIDTH - 2;
    localparam int unsigned CW    = ADDR_WIDTH - 1;
    localparam int unsigned DEPTH = 1 << WA;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_DBG  = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [CW-1:0]         word_count_q;
    logic                  load_done_q;
    logic                  load_err_q;
    logic                  dbg_ack_q;
    logic [DATA_WIDTH-1:0] dbg_rdata_q;
    logic                  accept;
    logic                  at_top;
    logic                  unused_dbg_lsb;

    assign accept         = (state_q == S_LOAD) && ld_valid_i && !rst;
    assign at_top         = (word_count_q == CW'(DEPTH - 1));
    assign unused_dbg_lsb = ^dbg_addr_i[1:0];

    // State register and registered status/debug outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_LOAD;
            word_count_q <= '0;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
            dbg_ack_q    <= 1'b0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            dbg_ack_q <= (state_q == S_DBG);
            if (state_q == S_DBG) begin
                dbg_rdata_q <= mem_rdata_i;
            end
            if (accept) begin
                word_count_q <= word_count_q + CW'(1);
                if (ld_last_i) begin
                    load_done_q <= 1'b1;
                end else if (at_top) begin
                    load_done_q <= 1'b1;
                    load_err_q  <= 1'b1;
                end
            end
            if ((state_q == S_RUN) && reload_i) begin
                word_count_q <= '0;
                load_done_q  <= 1'b0;
                load_err_q   <= 1'b0;
            end
        end
    end

    // Next-state: reload beats debug; no debug accept in the ack cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_LOAD: if (accept && (ld_last_i || at_top)) state_d = S_RUN;
            S_RUN: begin
                if (reload_i) begin
                    state_d = S_LOAD;
                end else if (dbg_req_i && !dbg_ack_q) begin
                    state_d = S_DBG;
                end
            end
            S_DBG:   state_d = S_RUN;
            default: state_d = S_LOAD;
        endcase
    end

    // Memory port mux and handshake outputs, forced safe while in reset
    always_comb begin
        ld_ready_o    = 1'b0;
        core_stall_o  = 1'b1;
        fetch_fault_o = 1'b0;
        mem_we_o      = 1'b0;
        mem_addr_o    = word_count_q[WA-1:0];
        mem_wdata_o   = ld_data_i;
        unique case (state_q)
            S_LOAD: begin
                ld_ready_o = 1'b1;
                mem_we_o   = ld_valid_i;
            end
            S_RUN: begin
                mem_addr_o    = fetch_addr_i[ADDR_WIDTH-1:2];
                core_stall_o  = 1'b0;
                fetch_fault_o = |fetch_addr_i[1:0];
            end
            S_DBG: begin
                mem_addr_o = dbg_addr_i[ADDR_WIDTH-1:2];
            end
            default: ;
        endcase
        if (rst) begin
            ld_ready_o    = 1'b0;
            mem_we_o      = 1'b0;
            core_stall_o  = 1'b1;
            fetch_fault_o = 1'b0;
        end
    end

    assign fetch_instr_o = mem_rdata_i;
    assign dbg_ack_o     = dbg_ack_q && !rst;
    assign dbg_rdata_o   = dbg_rdata_q;
    assign load_done_o   = load_done_q;
    assign load_err_o    = load_err_q;
    assign word_count_o  = word_count_q;

endmodule

// File: tb/tb_imem_boot_arbiter.sv
// Directed bench for imem_boot_arbiter with a behavioural async-read memory.
module tb_imem_boot_arbiter;

    localparam int unsigned AW    = 10;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 1 << (AW - 2);

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_valid, ld_last, ld_ready, reload;
    logic [DW-1:0] ld_data;
    logic [AW-1:0] fetch_addr, dbg_addr;
    logic [DW-1:0] fetch_instr, dbg_rdata, mem_wdata, mem_rdata;
    logic          core_stall, fetch_fault, dbg_req, dbg_ack, mem_we;
    logic          load_done, load_err;
    logic [AW-3:0] mem_addr;
    logic [AW-2:0] word_count;

    logic [DW-1:0] mem [DEPTH];
    int            wr_count = 0;
    int            n_checks = 0;
    int            n_pass   = 0;

    always #5 clk = ~clk;

    imem_boot_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .ld_valid_i(ld_valid), .ld_data_i(ld_data), .ld_last_i(ld_last), .ld_ready_o(ld_ready),
        .reload_i(reload), .fetch_addr_i(fetch_addr), .fetch_instr_o(fetch_instr),
        .core_stall_o(core_stall), .fetch_fault_o(fetch_fault),
        .dbg_req_i(dbg_req), .dbg_addr_i(dbg_addr), .dbg_ack_o(dbg_ack), .dbg_rdata_o(dbg_rdata),
        .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .load_done_o(load_done), .load_err_o(load_err), .word_count_o(word_count)
    );

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wr_count      <= wr_count + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    logic [DW-1:0] prog [4] = '{32'h00100093, 32'h00200113, 32'h002081B3, 32'h0000006F};
    logic          vpat [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        int wr0;
        int idx;
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
        rst = 1'b1; ld_valid = 1'b1; ld_data = 32'hDEAD_BEEF; ld_last = 1'b0; reload = 1'b0;
        fetch_addr = '0; dbg_req = 1'b0; dbg_addr = '0;

        // Reset behaviour
        @(negedge clk); #1;
        check("rst_ld_ready", ld_ready, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_stall", core_stall, 1);
        check("rst_dbg_ack", dbg_ack, 0);
        @(negedge clk);
        rst = 1'b0; ld_valid = 1'b0; dbg_req = 1'b1; dbg_addr = 10'h4; #1;
        check("rst_count", word_count, 0);
        check("rst_done", load_done, 0);
        check("rst_err", load_err, 0);
        check("rst_rdata", dbg_rdata, 0);
        check("load_ready", ld_ready, 1);

        // Load 4 words, debug request pending throughout
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ld_valid = 1'b1; ld_data = prog[i]; ld_last = (i == 3); #1;
            check($sformatf("ld4_we%0d", i), mem_we, 1);
            check($sformatf("ld4_addr%0d", i), mem_addr, 64'(i));
            check($sformatf("ld4_stall%0d", i), core_stall, 1);
        end
        @(negedge clk);
        ld_valid = 1'b0; ld_last = 1'b0; dbg_req = 1'b0; #1;
        check("ld4_stall_after", core_stall, 0);
        check("ld4_ready_after", ld_ready, 0);
        check("ld4_done", load_done, 1);
        check("ld4_err", load_err, 0);
        check("ld4_count", word_count, 4);
        check("ld4_dbg_ack", dbg_ack, 0);
        for (int i = 0; i < 4; i++) check($sformatf("ld4_mem%0d", i), mem[i], prog[i]);

        // Fetch path
        fetch_addr = 10'h8; #1;
        check("fetch8_instr", fetch_instr, 32'h002081B3);
        check("fetch8_fault", fetch_fault, 0);
        fetch_addr = 10'h6; #1;
        check("fetch6_fault", fetch_fault, 1);
        check("fetch6_instr", fetch_instr, 32'h00200113);
        fetch_addr = 10'h0;

        // Held debug request: DBG at k=1,4; ack at k=2,5
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            dbg_req = 1'b1; dbg_addr = 10'h4; #1;
            check($sformatf("dbg_stall%0d", k), core_stall, 64'(k == 1 || k == 4));
            check($sformatf("dbg_ack%0d", k), dbg_ack, 64'(k == 2 || k == 5));
        end
        @(negedge clk);
        dbg_req = 1'b0; #1;
        check("dbg_stall6", core_stall, 0);
        check("dbg_ack6", dbg_ack, 0);
        check("dbg_rdata", dbg_rdata, 32'h00200113);

        // Reload, then a loader toggling valid
        @(negedge clk);
        reload = 1'b1; #1;
        check("reload_stall_now", core_stall, 0);
        @(negedge clk);
        reload = 1'b0; #1;
        check("reload_ready", ld_ready, 1);
        check("reload_count", word_count, 0);
        check("reload_done", load_done, 0);
        wr0 = wr_count; idx = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ld_valid = vpat[i]; ld_data = 32'hB000_0000 + 32'(idx); ld_last = (i == 4); #1;
            check($sformatf("tog_we%0d", i), mem_we, 64'(vpat[i]));
            check($sformatf("tog_stall%0d", i), core_stall, 1);
            check($sformatf("tog_count%0d", i), word_count, 64'(idx));
            if (vpat[i]) idx++;
        end
        @(negedge clk);
        ld_valid = 1'b0; ld_last = 1'b0; #1;
        check("tog_writes", 64'(wr_count - wr0), 3);
        check("tog_count", word_count, 3);
        check("tog_stall_after", core_stall, 0);
        check("tog_mem2", mem[2], 32'hB000_0002);

        // Reload, then reset mid-load
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            ld_valid = 1'b1; ld_data = 32'hC000_0000;
        end
        @(negedge clk);
        rst = 1'b1; #1;
        check("rstmid_ready", ld_ready, 0);
        check("rstmid_we", mem_we, 0);
        check("rstmid_stall", core_stall, 1);
        @(negedge clk);
        rst = 1'b0; ld_valid = 1'b0; #1;
        check("rstmid_count", word_count, 0);
        check("rstmid_done", load_done, 0);
        check("rstmid_ready_after", ld_ready, 1);

        // Fill all words without last
        for (int i = 0; i < int'(DEPTH); i++) begin
            @(negedge clk);
            ld_valid = 1'b1; ld_data = 32'hA000_0000 + 32'(i); ld_last = 1'b0;
            if (i == int'(DEPTH) - 1) begin
                #1;
                check("fill_stall_last", core_stall, 1);
                check("fill_err_before", load_err, 0);
            end
        end
        @(negedge clk);
        ld_valid = 1'b0; #1;
        check("fill_err", load_err, 1);
        check("fill_done", load_done, 1);
        check("fill_ready", ld_ready, 0);
        check("fill_stall", core_stall, 0);
        check("fill_count", word_count, 64'(DEPTH));
        check("fill_mem_top", mem[DEPTH-1], 32'hA000_00FF);
        fetch_addr = 10'h190; #1;
        check("fill_fetch", fetch_instr, 32'hA000_0064);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
